// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encodings, slice op codes and sequencer states
package alu_pkg;

    // Full 4-bit ALU control words: {A_invert, B_invert, operation[1:0]}
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Slice operation field
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_top.sv
// rtl/alu_top.sv - 1-bit ALU slice (AND/OR/ADD/LESS with operand inversion)
//
// Ports:
//   src1, src2        operand bits
//   less              value forwarded when operation selects LESS
//   A_invert/B_invert invert the corresponding operand bit before use
//   cin               carry in
//   operation         00 AND, 01 OR, 10 SUM, 11 LESS
//   result            selected output bit
//   cout              full-adder carry out (always computed)
module alu_top
    import alu_pkg::*;
(
    input  logic       src1,
    input  logic       src2,
    input  logic       less,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout
);

    logic a_bit;
    logic b_bit;
    logic sum_bit;

    assign a_bit   = src1 ^ A_invert;
    assign b_bit   = src2 ^ B_invert;
    assign sum_bit = a_bit ^ b_bit ^ cin;
    assign cout    = (a_bit & b_bit) | (a_bit & cin) | (b_bit & cin);

    always_comb begin
        result = 1'b0;
        case (operation)
            OP_AND:  result = a_bit & b_bit;
            OP_OR:   result = a_bit | b_bit;
            OP_ADD:  result = sum_bit;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_seq.sv
// rtl/bit_serial_alu_seq.sv - bit-serial sequencer driving one alu_top slice over a WIDTH-bit word
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start_i         request pulse, accepted in IDLE or DONE
//   ctrl_i          {A_invert, B_invert, operation[1:0]}
//   src1_i, src2_i  operands, latched on the accepting edge
//   busy_o          high while bits are processed
//   done_o          one-cycle pulse when result/flags are valid
//   result_o        result word, held until the next accepted start
//   zero_o          result_o == 0
//   cout_o          final carry for ADD/SLT style ops, else 0
//   overflow_o      signed overflow for ADD style ops, else 0
module bit_serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [3:0]       ctrl_q,   ctrl_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic             slice_result;
    logic             slice_cout;
    logic [1:0]       slice_op;
    logic [WIDTH-1:0] final_word;
    logic [WIDTH-1:0] final_result;
    logic             ovf_msb;

    // SLT is run through the adder so the MSB sum bit can be observed;
    // the LESS input of the slice is never used by this sequencer.
    assign slice_op = (ctrl_q[1:0] == OP_SLT) ? OP_ADD : ctrl_q[1:0];

    alu_top u_slice (
        .src1      (a_q[cnt_q]),
        .src2      (b_q[cnt_q]),
        .less      (1'b0),
        .A_invert  (ctrl_q[3]),
        .B_invert  (ctrl_q[2]),
        .cin       (carry_q),
        .operation (slice_op),
        .result    (slice_result),
        .cout      (slice_cout)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        ctrl_d       = ctrl_q;
        work_d       = work_q;
        result_d     = result_q;
        zero_d       = zero_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        final_word   = work_q;
        final_result = work_q;
        // Carry into the MSB (carry_q while on the last bit) vs carry out of it
        ovf_msb      = carry_q ^ slice_cout;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    a_d      = src1_i;
                    b_d      = src2_i;
                    ctrl_d   = ctrl_i;
                    cnt_d    = '0;
                    // Subtraction needs +1 after inverting B
                    carry_d  = ctrl_i[2];
                    work_d   = '0;
                    result_d = '0;
                    zero_d   = 1'b0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_RUN: begin
                work_d[cnt_q] = slice_result;
                carry_d       = slice_cout;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    final_word            = work_q;
                    final_word[WIDTH-1]   = slice_result;
                    cnt_d                 = '0;
                    state_d               = ST_DONE;
                    case (ctrl_q[1:0])
                        OP_SLT: begin
                            // Sign of the difference, corrected for overflow
                            final_result    = '0;
                            final_result[0] = slice_result ^ ovf_msb;
                            cout_d          = slice_cout;
                            ovf_d           = 1'b0;
                        end
                        OP_ADD: begin
                            final_result = final_word;
                            cout_d       = slice_cout;
                            ovf_d        = ovf_msb;
                        end
                        default: begin
                            final_result = final_word;
                            cout_d       = 1'b0;
                            ovf_d        = 1'b0;
                        end
                    endcase
                    result_d = final_result;
                    zero_d   = (final_result == '0);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            work_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            work_q   <= work_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb/tb_bit_serial_alu_seq.sv - directed self-checking bench for bit_serial_alu_seq
module tb_bit_serial_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    int checks;
    int failures;
    int lat;
    int busy_n;
    int done_seen;

    bit_serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .ctrl_i     (ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Issues start, scrambles operands after the start
    // edge, and returns at the negedge where done_o is seen (lat = edges after
    // the start edge, -1 on timeout). glitch_at >= 0 injects a stray start pulse.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_at, output int lat_o, output int busy_o_n);
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
        ctrl_i  = 4'($urandom);
        lat_o    = -1;
        busy_o_n = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done_o) begin
                lat_o = n;
                break;
            end
            if (busy_o) busy_o_n++;
            if (n == glitch_at) begin
                start_i = 1'b1;
                ctrl_i  = ALU_SUB;
                src1_i  = 32'h1234_5678;
                src2_i  = 32'h0000_0001;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [31:0] res, input logic z,
                               input logic co, input logic ov);
        check_eq({tag, "_res"},  result_o,   res);
        check_eq({tag, "_zero"}, {31'd0, zero_o},     {31'd0, z});
        check_eq({tag, "_cout"}, {31'd0, cout_o},     {31'd0, co});
        check_eq({tag, "_ovf"},  {31'd0, overflow_o}, {31'd0, ov});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        ctrl_i   = 4'd0;
        src1_i   = '0;
        src2_i   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_flags("rst", 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD overflow, with timing
        do_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, -1, lat, busy_n);
        check_eq("add_lat",  32'(lat),    32'd32);
        check_eq("add_busy", 32'(busy_n), 32'd32);
        check_flags("add", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done_o}, 32'd0);

        do_op(ALU_SUB, 32'd5, 32'd5, -1, lat, busy_n);
        check_flags("sub", 32'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);

        do_op(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, -1, lat, busy_n);
        check_flags("slt_neg", 32'd1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        do_op(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, -1, lat, busy_n);
        check_flags("slt_ovf", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        do_op(ALU_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, -1, lat, busy_n);
        check_flags("nor", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        do_op(ALU_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, -1, lat, busy_n);
        check_flags("and", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        do_op(ALU_OR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, -1, lat, busy_n);
        check_flags("or", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Stray start mid-RUN must be ignored
        do_op(ALU_ADD, 32'd3, 32'd4, 5, lat, busy_n);
        check_eq("glitch_lat", 32'(lat), 32'd32);
        check_flags("glitch", 32'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("glitch_idle", {31'd0, busy_o}, 32'd0);

        // Reset while processing bit 10
        start_i = 1'b1;
        ctrl_i  = ALU_ADD;
        src1_i  = 32'd100;
        src2_i  = 32'd200;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
        check_eq("abort_res",  result_o, 32'd0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        check_eq("abort_nodone", 32'(done_seen), 32'd0);

        do_op(ALU_ADD, 32'd3, 32'd4, -1, lat, busy_n);
        check_flags("post_rst", 32'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Back-to-back: start held in the DONE cycle
        do_op(ALU_ADD, 32'h10, 32'h20, -1, lat, busy_n);
        check_eq("b2b_first", result_o, 32'h30);
        do_op(ALU_SUB, 32'd10, 32'd3, -1, lat, busy_n);
        check_eq("b2b_lat", 32'(lat), 32'd32);
        check_flags("b2b_sub", 32'd7, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("b2b_idle", {31'd0, done_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
